// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline stage register.
//   pipe_state_e  - occupancy state of a stage (EMPTY / ONE / TWO)
//   PIPE_CTRL_W   - default control bundle width
//   PIPE_NOP_CTRL - control value presented downstream for a bubble
//   pipe_occ()    - entry count for a given state
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pipe_state_e;

  localparam int unsigned PIPE_CTRL_W = 8;

  // All-zero control is a NOP for every downstream stage.
  localparam logic [PIPE_CTRL_W-1:0] PIPE_NOP_CTRL = '0;

  function automatic logic [1:0] pipe_occ(input pipe_state_e s);
    logic [1:0] n;
    n = 2'd0;
    case (s)
      PS_ONE:  n = 2'd1;
      PS_TWO:  n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: W-bit holding register used for the main (M) and skid (S)
// entries of a pipeline stage.
// Ports:
//   clk_i    in   clock
//   rst_n_i  in   asynchronous active-low clear
//   clr_i    in   synchronous clear (wins over load)
//   load_i   in   load enable
//   d_i      in   W  next value
//   q_o      out  W  held value
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned W = 32 + PIPE_CTRL_W
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q_o <= '0;
    end else if (clr_i) begin
      q_o <= '0;
    end else if (load_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register carrying a payload
// and a control bundle between two stages over a valid/ready handshake,
// with backpressure stall, synchronous flush and NOP bubbles.
//
// Build option: define PIPE_STAGE_SKID_EN for a two-entry skid buffer whose
// in_ready_o comes straight from registered state. Without it the stage is a
// single register with in_ready_o = out_ready_i || !out_valid_o.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high on that side. A producer holding valid must keep its data stable
// until the transfer; out_* never change while out_valid_o && !out_ready_i.
//
// Ports:
//   clk_i        in   clock
//   rst_n_i      in   asynchronous active-low reset
//   flush_i      in   squash held entries and this cycle's input
//   in_valid_i   in   upstream entry present
//   in_ready_o   out  stage can accept
//   in_data_i    in   WIDTH   upstream payload
//   in_ctrl_i    in   CTRL_W  upstream control bundle
//   out_valid_o  out  downstream entry present
//   out_ready_i  in   downstream accepts (0 = stall)
//   out_data_o   out  WIDTH   payload of the oldest entry
//   out_ctrl_o   out  CTRL_W  control of the oldest entry, 0 when not valid
//   occ_o        out  2       entries held
//   state_o      out  current occupancy state (debug)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned CTRL_W     = PIPE_CTRL_W,
  parameter bit          CLEAR_DATA = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WIDTH-1:0]  in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WIDTH-1:0]  out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [1:0]        occ_o,
  output pipe_state_e       state_o
);

  localparam int unsigned SW = WIDTH + CTRL_W;

  pipe_state_e   state;
  logic          out_valid;
  logic          in_fire;
  logic          out_fire;
  logic          m_load;
  logic [SW-1:0] m_d;
  logic [SW-1:0] m_q;

  assign out_valid = (state != PS_EMPTY);

`ifdef PIPE_STAGE_SKID_EN
  logic          s_load;
  logic [SW-1:0] s_q;

  // Registered ready: the skid slot absorbs the entry that arrives in the
  // cycle the downstream stall is first seen.
  assign in_ready_o = (state != PS_TWO);
`else
  assign in_ready_o = out_ready_i || !out_valid;
`endif

  assign in_fire  = in_valid_i && in_ready_o;
  assign out_fire = out_valid && out_ready_i;

  // Slot load decode. M always holds the older entry; S only fills when M is
  // stalled and a new entry arrives.
  always_comb begin
    m_load = 1'b0;
    m_d    = {in_ctrl_i, in_data_i};
`ifdef PIPE_STAGE_SKID_EN
    s_load = 1'b0;
    if (!flush_i) begin
      case (state)
        PS_EMPTY: m_load = in_fire;
        PS_ONE: begin
          m_load = in_fire && out_fire;
          s_load = in_fire && !out_fire;
        end
        PS_TWO: begin
          m_load = out_fire;
          m_d    = s_q;
        end
        default: m_load = 1'b0;
      endcase
    end
`else
    m_load = in_fire && !flush_i;
`endif
  end

  // Occupancy state machine; flush beats every other event.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= PS_EMPTY;
    end else if (flush_i) begin
      state <= PS_EMPTY;
    end else begin
      case (state)
        PS_EMPTY: if (in_fire) state <= PS_ONE;
        PS_ONE: begin
`ifdef PIPE_STAGE_SKID_EN
          if (in_fire && !out_fire) state <= PS_TWO;
          else if (!in_fire && out_fire) state <= PS_EMPTY;
`else
          if (!in_fire && out_fire) state <= PS_EMPTY;
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        PS_TWO: if (out_fire) state <= PS_ONE;
`endif
        default: state <= PS_EMPTY;
      endcase
    end
  end

  pipe_slot #(.W(SW)) u_slot_m (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (flush_i && CLEAR_DATA),
    .load_i  (m_load),
    .d_i     (m_d),
    .q_o     (m_q)
  );

`ifdef PIPE_STAGE_SKID_EN
  pipe_slot #(.W(SW)) u_slot_s (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (flush_i),
    .load_i  (s_load),
    .d_i     ({in_ctrl_i, in_data_i}),
    .q_o     (s_q)
  );
`endif

  assign out_valid_o = out_valid;
  // Control is masked to a NOP whenever no entry is presented, so a bubble
  // can never carry live write-enables downstream.
  assign out_ctrl_o  = out_valid ? m_q[SW-1:WIDTH] : CTRL_W'(PIPE_NOP_CTRL);
  assign out_data_o  = (out_valid || !CLEAR_DATA) ? m_q[WIDTH-1:0] : '0;
  assign occ_o       = pipe_occ(state);
  assign state_o     = state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: self-checking bench for pipe_stage_reg. Works for both
// builds (PIPE_STAGE_SKID_EN defined or not). A second instance with
// CLEAR_DATA = 1 shares all inputs to cover data clearing on bubbles.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int W  = 32;
  localparam int CW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          out_ready = 1'b0;

  logic          in_ready, out_valid;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occ;
  pipe_state_e   state_dbg;

  logic          c_in_ready, c_out_valid;
  logic [W-1:0]  c_out_data;
  logic [CW-1:0] c_out_ctrl;
  logic [1:0]    c_occ;
  pipe_state_e   c_state_dbg;

  pipe_stage_reg #(.WIDTH(W), .CTRL_W(CW), .CLEAR_DATA(1'b0)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_ctrl_i(in_ctrl),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_ctrl_o(out_ctrl),
    .occ_o(occ), .state_o(state_dbg)
  );

  pipe_stage_reg #(.WIDTH(W), .CTRL_W(CW), .CLEAR_DATA(1'b1)) dut_clr (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(c_in_ready),
    .in_data_i(in_data), .in_ctrl_i(in_ctrl),
    .out_valid_o(c_out_valid), .out_ready_i(out_ready),
    .out_data_o(c_out_data), .out_ctrl_o(c_out_ctrl),
    .occ_o(c_occ), .state_o(c_state_dbg)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [W+CW-1:0] exp_q[$];
  int mdl_occ = 0;

  always @(negedge clk) begin
    logic exp_ready, in_f, out_f;
    if (!rst_n) begin
      check_eq("rst_valid", out_valid, 0);
      check_eq("rst_ctrl", out_ctrl, 0);
      check_eq("rst_data", out_data, 0);
      check_eq("rst_occ", occ, 0);
      exp_q.delete();
      mdl_occ = 0;
    end else begin
`ifdef PIPE_STAGE_SKID_EN
      exp_ready = (mdl_occ != 2);
`else
      exp_ready = out_ready || (mdl_occ == 0);
`endif
      check_eq("in_ready", in_ready, exp_ready);
      check_eq("c_in_ready", c_in_ready, exp_ready);
      check_eq("occ", occ, mdl_occ);
      check_eq("out_valid", out_valid, mdl_occ != 0);
      check_eq("c_out_valid", c_out_valid, mdl_occ != 0);
      if (mdl_occ != 0 && exp_q.size() > 0) begin
        check_eq("head", {out_ctrl, out_data}, exp_q[0]);
        check_eq("c_head", {c_out_ctrl, c_out_data}, exp_q[0]);
      end else if (mdl_occ == 0) begin
        check_eq("bubble_ctrl", out_ctrl, 0);
        check_eq("c_bubble_ctrl", c_out_ctrl, 0);
        check_eq("c_bubble_data", c_out_data, 0);
      end
      in_f  = in_valid && exp_ready;
      out_f = (mdl_occ != 0) && out_ready;
      if (flush) begin
        exp_q.delete();
        mdl_occ = 0;
      end else begin
        if (out_f) begin
          void'(exp_q.pop_front());
          mdl_occ--;
        end
        if (in_f) begin
          exp_q.push_back({in_ctrl, in_data});
          mdl_occ++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold an entry on the input until the stage takes it.
  task automatic send(input logic [W-1:0] d, input logic [CW-1:0] c);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      step();
    end
    if (!done) check_eq("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] vals[3];
    logic [0:0]   rdy_seq[3];
    vals    = '{32'h11, 32'h22, 32'h33};
    rdy_seq = '{1'b1, 1'b0, 1'b1};

    // Power-on reset.
    repeat (3) step();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("por_in_ready", in_ready, 1);
    step();

    // Streaming at full rate.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = vals[i];
      in_ctrl  = 8'h80 + 8'(i);
      @(negedge clk);
      if (i > 0) begin
        check_eq("stream_data", out_data, vals[i-1]);
        check_eq("stream_occ", occ, 1);
      end
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("stream_last", out_data, vals[2]);
    step();
    repeat (2) step();

    // Stall with three entries offered.
    out_ready = 1'b0;
    fork
      begin
        send(32'hA, 8'h0A);
        send(32'hB, 8'h0B);
        send(32'hC, 8'h0C);
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("stall_head", out_data, 32'hA);
        check_eq("stall_in_ready", in_ready, 0);
`ifdef PIPE_STAGE_SKID_EN
        check_eq("stall_occ", occ, 2);
`else
        check_eq("stall_occ", occ, 1);
`endif
        step();
        out_ready = 1'b1;
      end
    join
    repeat (4) step();
    check_eq("stall_drained", exp_q.size(), 0);

    // Flush while full, with a live input in the flush cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 32'h66; in_ctrl = 8'h66;
    step();
    in_data = 32'h77; in_ctrl = 8'h77;
    step();
    flush = 1'b1; in_data = 32'h55; in_ctrl = 8'h55;
    @(negedge clk);
`ifdef PIPE_STAGE_SKID_EN
    check_eq("pre_flush_occ", occ, 2);
`else
    check_eq("pre_flush_occ", occ, 1);
`endif
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_eq("flush_valid", out_valid, 0);
    check_eq("flush_ctrl", out_ctrl, 0);
    check_eq("flush_occ", occ, 0);
    step();
    out_ready = 1'b1;
    repeat (3) step();

    // Bubble with live-looking control on the input.
    send(32'h44, 8'h5A);
    in_ctrl = 8'hFF; in_data = 32'hDEAD;
    step();
    @(negedge clk);
    check_eq("bub_valid", out_valid, 0);
    check_eq("bub_ctrl", out_ctrl, 0);
    check_eq("bub_hold_data", out_data, 32'h44);
    check_eq("bub_clr_data", c_out_data, 0);
    step();

`ifndef PIPE_STAGE_SKID_EN
    // Combinational ready follows downstream ready while full.
    out_ready = 1'b0;
    send(32'h60, 8'h60);
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      in_data   = 32'h70 + 32'(i);
      in_ctrl   = 8'h70 + 8'(i);
      out_ready = rdy_seq[i][0];
      #1;
      check_eq("ns_ready_follow", in_ready, rdy_seq[i][0]);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
`endif

    // Reset mid-stream while an entry is presented.
    out_ready = 1'b0;
    send(32'h99, 8'h99);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", out_valid, 0);
    check_eq("async_rst_ctrl", out_ctrl, 0);
    check_eq("async_rst_data", out_data, 0);
    check_eq("async_rst_occ", occ, 0);
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel_in_ready", in_ready, 1);
    step();

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom();
      in_ctrl   = 8'($urandom_range(1, 255));
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 24) == 0);
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    check_eq("final_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
